// File: rtl/conv_pkg.sv
// Shared convolution datapath types: pixel/patch layout and window FSM states.
// Used by patch_window_generator and hadamard_product_unit.
package conv_pkg;
   localparam int WIDTH = 32;
   localparam int K     = 3;
   localparam int SIZE  = K * K;

   typedef logic [WIDTH-1:0] pixel_t;
   typedef pixel_t [SIZE-1:0] patch_t;

   typedef enum logic {
      FILL,
      STREAM
   } win_state_e;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixels; read and write share an index, read returns old value.
// Ports: clk, we_i (write strobe), idx_i (column), wdata_i (new pixel), rdata_o (old pixel).
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] idx_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);
   pixel_t mem_q [DEPTH];

   // Asynchronous read: the value seen this cycle is the pre-write content.
   assign rdata_o = mem_q[idx_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
   end
endmodule

// File: rtl/patch_window_generator.sv
// Turns a raster pixel stream into every valid 3x3 patch (no padding).
// Ports: clk, rst_n (sync, active-low), in_* pixel handshake, out_* patch handshake + out_last.
module patch_window_generator
   import conv_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH-1:0]            in_pixel,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [SIZE-1:0][WIDTH-1:0]  out_patch,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   win_state_e    state_q;
   patch_t        win_q, win_d;
   patch_t        out_patch_q;
   logic          out_valid_q, out_last_q;
   pixel_t        lb0_rd, lb1_rd;
   logic          accept, col_wrap, row_wrap, emit;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign col_wrap  = (col_q == CW'(IMG_W - 1));
   assign row_wrap  = (row_q == RW'(IMG_H - 1));
   assign emit      = accept && (state_q == STREAM) && (col_q >= CW'(2));

   assign out_patch = out_patch_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

   // lb0 holds the previous row, lb1 the one before; a pixel ages lb0 -> lb1.
   line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .clk     (clk),
      .we_i    (accept),
      .idx_i   (col_q),
      .wdata_i (in_pixel),
      .rdata_o (lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk     (clk),
      .we_i    (accept),
      .idx_i   (col_q),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   // Shift left one column; new right column is {row r-2, row r-1, row r}.
   always_comb begin
      win_d = win_q;
      for (int dr = 0; dr < K; dr++) begin
         win_d[K*dr]     = win_q[K*dr + 1];
         win_d[K*dr + 1] = win_q[K*dr + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_pixel;
   end

   // Window contents are data only; stale columns are never emitted.
   always_ff @(posedge clk) begin
      if (accept) win_q <= win_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         state_q     <= FILL;
         out_patch_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         if (out_ready) out_valid_q <= 1'b0;
         if (accept) begin
            col_q <= col_wrap ? '0 : col_q + CW'(1);
            if (col_wrap) row_q <= row_wrap ? '0 : row_q + RW'(1);
            unique case (state_q)
               FILL:   if (col_wrap && row_q == RW'(1)) state_q <= STREAM;
               STREAM: if (col_wrap && row_wrap)        state_q <= FILL;
               default: state_q <= FILL;
            endcase
            if (emit) begin
               out_patch_q <= win_d;
               out_valid_q <= 1'b1;
               out_last_q  <= col_wrap && row_wrap;
            end
         end
      end
   end
endmodule

// File: tb/tb_patch_window_generator.sv
// Scoreboard bench for patch_window_generator on a 4x4 image.
// Stimulus pushes expected patches; a negedge monitor pops on each handshake.
module tb_patch_window_generator;
   import conv_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   pixel_t in_pixel = '0;
   logic   in_valid = 1'b0;
   logic   in_ready;
   patch_t out_patch;
   logic   out_valid;
   logic   out_ready = 1'b1;
   logic   out_last;

   typedef struct packed {
      patch_t p;
      logic   last;
   } exp_t;

   exp_t   sbq[$];
   int     checks = 0;
   int     errors = 0;
   int     lasts = 0;
   logic   bp_arm = 1'b0;
   patch_t held;

   int exp_tbl [4][9] = '{
      '{1, 2, 3, 5, 6, 7, 9, 10, 11},
      '{2, 3, 4, 6, 7, 8, 10, 11, 12},
      '{5, 6, 7, 9, 10, 11, 13, 14, 15},
      '{6, 7, 8, 10, 11, 12, 14, 15, 16}
   };

   always #5 clk = ~clk;

   patch_window_generator #(.IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_pixel  (in_pixel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_patch (out_patch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_patch(input string nm, input patch_t act,
                            input patch_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic patch_t tbl_patch(input int k, input int base);
      patch_t p;
      for (int e = 0; e < SIZE; e++) p[e] = pixel_t'(exp_tbl[k][e] + base);
      return p;
   endfunction

   task automatic push_frame(input int base);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.p    = tbl_patch(k, base);
         e.last = (k == 3);
         sbq.push_back(e);
      end
   endtask

   task automatic send(input int v);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      in_pixel = pixel_t'(v);
      in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout pixel=%0d actual=stalled required=accept", v);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit gaps);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send(base + W * r + c + 1);
         end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue", sbq.size(), 0);
   endtask

   // Monitor: a handshake completes at the next edge when valid&&ready now.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_patch actual=%h required=none", out_patch);
         end else begin
            e = sbq.pop_front();
            chk_patch("patch", out_patch, e.p);
            chk("last", out_last, e.last);
            if (out_last) lasts++;
         end
      end
   end

   // Backpressure: stall the first patch seen while armed for 5 cycles.
   initial forever begin
      @(posedge clk);
      #1;
      if (bp_arm && out_valid) begin
         bp_arm = 1'b0;
         out_ready = 1'b0;
         held = out_patch;
         chk_patch("bp_first", held, tbl_patch(0, 0));
         repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk_patch("bp_hold", out_patch, held);
            @(posedge clk);
            #1;
         end
         out_ready = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk_patch("rst_out_patch", out_patch, '0);
      rst_n = 1'b1;

      // Basic frame with latency probe around the 11th accept.
      push_frame(0);
      for (int i = 1; i <= 16; i++) begin
         send(i);
         if (i == 10) chk("lat_before", out_valid, 0);
         if (i == 11) chk("lat_first", out_valid, 1);
      end
      drain();

      // Backpressure on the first patch.
      bp_arm = 1'b1;
      push_frame(0);
      send_frame(0, 1'b0);
      drain();

      // Random input gaps.
      push_frame(0);
      send_frame(0, 1'b1);
      drain();

      // Back-to-back frames.
      push_frame(0);
      push_frame(100);
      send_frame(0, 1'b0);
      send_frame(100, 1'b0);
      drain();

      // Reset mid-frame after 9 accepts, then a fresh frame.
      for (int i = 1; i <= 9; i++) send(i);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      push_frame(0);
      send_frame(0, 1'b0);
      drain();

      chk("last_count", lasts, 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
